dmux_dispatch_ctrl: RTL and testbench

- Dispatch controller for the 1-to-8 demultiplexer path.
- Accepts data words on a valid/ready input and holds one word in a register.
- Routes each word to exactly one of 8 output channels, either round-robin or by explicit destination.
- A per-word timeout drops words whose target channel never accepts, and a saturating drop counter records each drop.

---
 rtl/dmux_dispatch_ctrl_if.sv | 27 ++
 rtl/dmux_dispatch_ctrl.sv | 105 ++++++++++
 tb/tb_dmux_dispatch_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmux_dispatch_ctrl_if.sv
// Bundle of the dispatch controller's input handshake, channel side and status signals.
// The slave modport is the controller's view; master is the driving environment.
interface dmux_dispatch_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              mode;
  logic [2:0]        dest;
  logic [7:0]        ch_ready;
  logic [7:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        sel;
  logic              busy;
  logic [7:0]        drop_cnt;

  modport slave (
    input  in_valid, in_data, mode, dest, ch_ready,
    output in_ready, out_valid, out_data, sel, busy, drop_cnt
  );

  modport master (
    output in_valid, in_data, mode, dest, ch_ready,
    input  in_ready, out_valid, out_data, sel, busy, drop_cnt
  );
endinterface

// File: rtl/dmux_dispatch_ctrl.sv
// One-word dispatch controller for a 1-to-8 demux: round-robin or directed routing,
// per-word timeout with saturating drop counter. Optional macro DMUX_SKIP_EN.
module dmux_dispatch_ctrl #(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 15
) (
  input logic                clk,
  input logic                rst,
  dmux_dispatch_ctrl_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [2:0]        sel_q, sel_nxt;
  logic [2:0]        rr_ptr, rr_nxt;
  logic [7:0]        wait_cnt, wait_nxt;
  logic [7:0]        drop_q, drop_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              held_rr, held_rr_nxt;

  logic       sel_ready;
  logic       xfer;
  logic       timeout;
  logic       accept;
  logic [2:0] next_rr;
  logic [2:0] rr_target;

`ifdef DMUX_SKIP_EN
  // First ready channel scanning circularly from start; falls back to start itself.
  function automatic logic [2:0] skip_target(input logic [2:0] start, input logic [7:0] rdy);
    logic [2:0] idx;
    skip_target = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (rdy[idx]) skip_target = idx;
    end
  endfunction
`endif

  assign sel_ready = bus.ch_ready[sel_q];
  assign xfer      = (state == HOLD) & sel_ready;
  assign timeout   = (state == HOLD) & ~sel_ready & (wait_cnt == 8'(HOLD_MAX - 1));
  assign accept    = bus.in_valid & bus.in_ready;
  assign next_rr   = ((xfer | timeout) & held_rr) ? sel_q + 3'd1 : rr_ptr;

`ifdef DMUX_SKIP_EN
  assign rr_target = skip_target(next_rr, bus.ch_ready);
`else
  assign rr_target = next_rr;
`endif

  assign bus.in_ready  = (state == IDLE) | xfer;
  assign bus.out_valid = (state == HOLD) ? (8'b1 << sel_q) : 8'b0;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state == HOLD);
  assign bus.drop_cnt  = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 3'd0;
      rr_ptr   <= 3'd0;
      wait_cnt <= 8'd0;
      drop_q   <= 8'd0;
      data_q   <= '0;
      held_rr  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      rr_ptr   <= rr_nxt;
      wait_cnt <= wait_nxt;
      drop_q   <= drop_nxt;
      data_q   <= data_nxt;
      held_rr  <= held_rr_nxt;
    end
  end

  // An accept takes priority; it can only coincide with a transfer, never a drop.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel_q;
    rr_nxt      = next_rr;
    wait_nxt    = wait_cnt;
    drop_nxt    = drop_q;
    data_nxt    = data_q;
    held_rr_nxt = held_rr;
    if (accept) begin
      state_nxt   = HOLD;
      data_nxt    = bus.in_data;
      wait_nxt    = 8'd0;
      sel_nxt     = bus.mode ? bus.dest : rr_target;
      held_rr_nxt = ~bus.mode;
    end else if (xfer) begin
      state_nxt = IDLE;
    end else if (timeout) begin
      state_nxt = IDLE;
      drop_nxt  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end else if (state == HOLD) begin
      wait_nxt = wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// Scoreboard bench for dmux_dispatch_ctrl: stimulus pushes expected deliveries,
// a negedge monitor pops and compares each channel transfer.
module tb_dmux_dispatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dmux_dispatch_ctrl_if #(.DATA_W(8)) bus ();

  dmux_dispatch_ctrl #(.DATA_W(8), .HOLD_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic m, input logic [2:0] d,
                               input logic [7:0] data, input logic [7:0] cr);
    bus.in_valid = v;
    bus.mode     = m;
    bus.dest     = d;
    bus.in_data  = data;
    bus.ch_ready = cr;
  endtask

  task automatic expectWord(input logic [2:0] s, input logic [7:0] data);
    exp_t e;
    e.sel  = s;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Every transfer seen on the channel side must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && ((bus.out_valid & bus.ch_ready) != 8'h00)) begin
      if (exp_q.size() == 0) begin
        assert_cnt++;
        fail_cnt++;
        $display("[TB] FAIL unexpected_delivery: sel=%0d data=0x%0h, expected none", bus.sel, bus.out_data);
      end else begin
        exp_t e;
        logic [7:0] oh;
        e  = exp_q.pop_front();
        oh = 8'b1 << e.sel;
        checkOutput("mon_sel", int'(bus.sel), int'(e.sel));
        checkOutput("mon_data", int'(bus.out_data), int'(e.data));
        checkOutput("mon_onehot", int'(bus.out_valid), int'(oh));
      end
    end
  end

  initial begin
    int hold;
    bit done;
    $display("[TB] start");
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_drop_cnt", int'(bus.drop_cnt), 0);
    checkOutput("rst_sel", int'(bus.sel), 0);
    checkOutput("rst_out_data", int'(bus.out_data), 0);
    checkOutput("rst_in_ready", int'(bus.in_ready), 1);
    step();

    // Back-to-back round-robin words
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 8'(i), 8'hFF);
      expectWord(3'(i % 8), 8'(i));
      @(negedge clk);
      checkOutput("rr_in_ready", int'(bus.in_ready), 1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    @(negedge clk);
    checkOutput("rr_idle_busy", int'(bus.busy), 0);
    step();

    // Directed word to channel 5, stalled 3 cycles
    applyStimulus(1'b1, 1'b1, 3'd5, 8'hA5, 8'h00);
    expectWord(3'd5, 8'hA5);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("dir_out_valid_stall", int'(bus.out_valid), 'h20);
      checkOutput("dir_in_ready_stall", int'(bus.in_ready), 0);
      step();
    end
    bus.ch_ready = 8'h20;
    @(negedge clk);
    checkOutput("dir_out_valid_go", int'(bus.out_valid), 'h20);
    checkOutput("dir_in_ready_go", int'(bus.in_ready), 1);
    step();
    @(negedge clk);
    checkOutput("dir_done_busy", int'(bus.busy), 0);
    step();

    // Round-robin resumes at 2 after the directed word
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h77, 8'hFF);
    expectWord(3'd2, 8'h77);
    step();
    bus.in_valid = 1'b0;
    step();
    step();

    // Reset while holding with wait_cnt=7
    applyStimulus(1'b1, 1'b1, 3'd3, 8'h5A, 8'h00);
    step();
    bus.in_valid = 1'b0;
    repeat (7) step();
    @(negedge clk);
    checkOutput("prerst_busy", int'(bus.busy), 1);
    checkOutput("prerst_sel", int'(bus.sel), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("hrst_out_valid", int'(bus.out_valid), 0);
    checkOutput("hrst_busy", int'(bus.busy), 0);
    checkOutput("hrst_drop_cnt", int'(bus.drop_cnt), 0);
    checkOutput("hrst_sel", int'(bus.sel), 0);
    step();

    // Round-robin timeout: rr_ptr is 0 after reset
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h33, 8'h00);
    step();
    bus.in_valid = 1'b0;
    hold = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        if (hold == 0) checkOutput("to_sel", int'(bus.sel), 0);
        hold++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    checkOutput("to_hold_cycles", hold, 15);
    checkOutput("to_drop_cnt", int'(bus.drop_cnt), 1);
    checkOutput("to_busy", int'(bus.busy), 0);
    step();
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h44, 8'hFF);
    expectWord(3'd1, 8'h44);
    step();
    bus.in_valid = 1'b0;
    step();
    step();

    // Round-robin with rr_ptr=2 and only channel 6 ready
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h66, 8'h40);
`ifdef DMUX_SKIP_EN
    expectWord(3'd6, 8'h66);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("skip_sel", int'(bus.sel), 6);
    checkOutput("skip_out_valid", int'(bus.out_valid), 'h40);
    step();
    @(negedge clk);
    checkOutput("skip_done_busy", int'(bus.busy), 0);
    step();
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h67, 8'hFF);
    expectWord(3'd7, 8'h67);
`else
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("noskip_sel", int'(bus.sel), 2);
    checkOutput("noskip_out_valid", int'(bus.out_valid), 'h04);
    checkOutput("noskip_in_ready", int'(bus.in_ready), 0);
    step();
    @(negedge clk);
    checkOutput("noskip_wait_busy", int'(bus.busy), 1);
    checkOutput("noskip_wait_sel", int'(bus.sel), 2);
    expectWord(3'd2, 8'h66);
    bus.ch_ready = 8'hFF;
    step();
    step();
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h67, 8'hFF);
    expectWord(3'd3, 8'h67);
`endif
    step();
    bus.in_valid = 1'b0;
    step();
    step();

    // 260 directed timeouts saturate the drop counter
    for (int j = 0; j < 260; j++) begin
      applyStimulus(1'b1, 1'b1, 3'd0, 8'(j), 8'h00);
      step();
      bus.in_valid = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        @(negedge clk);
        if (!bus.busy) done = 1'b1;
        else step();
      end
      if (!done) begin
        assert_cnt++;
        fail_cnt++;
        $display("[TB] FAIL sat_timeout_wait: busy still 1, expected 0 within 40 cycles");
      end
      if (j == 252) checkOutput("sat_drop_254", int'(bus.drop_cnt), 254);
      step();
    end
    @(negedge clk);
    checkOutput("sat_drop_255", int'(bus.drop_cnt), 255);

    repeat (3) step();
    checkOutput("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
